seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier. It is the sequential successor to the team's combinational `multiplier`.
- Computes one WIDTH x WIDTH product per transaction, unsigned or two's-complement signed, selected per operation.
- Uses valid/ready handshakes on both input and output.
- Intended for area-constrained datapaths where the single-cycle array multiplier is too large.

Parameters:
- WIDTH, 4, operand width in bits (>= 2). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = treat a, b as two's complement; 0 = unsigned
- out_valid  output  1  res holds a completed product
- out_ready  input  1  consumer accepts res
- res  output  2*WIDTH  product
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous and active-high on clk, as already decided.
  - Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, res = 0, all internal registers = 0.
  - Reset mid-operation aborts the operation; nothing is output.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch |a| into mcand and |b| into mult (magnitudes if signed_mode, raw otherwise). Latch neg = signed_mode & (a[W-1] ^ b[W-1]). Clear acc and count; go to RUN.
  - RUN: each cycle, if mult[0] then add mcand << count into acc (2W-bit). Then mult >>= 1, count++. Go to FIX when count == WIDTH-1 at the start of the cycle.
  - FIX: res <= neg ? -acc : acc (2W-bit two's complement). Go to DONE.
  - DONE: out_valid = 1 and res is held stable. On out_ready go to IDLE. in_ready stays 0 in DONE, so there is no accept in the same cycle as the output handshake.
- Latency: if the accept edge is t, the FSM enters FIX at t+WIDTH and out_valid is high from edge t+WIDTH+1. Throughput is one operation per WIDTH+3 cycles when out_ready is held high.
- Magnitude handling: |-2^(W-1)| = 2^(W-1) fits in WIDTH unsigned bits, so there is no overflow. The full signed product always fits in 2W bits.
- Inputs a, b and signed_mode are ignored outside the accept cycle. Changing them mid-operation has no effect.
- res keeps its last value in IDLE until the next FIX.
- out_ready is ignored when out_valid = 0.

Optional Feature:
- Macro: SEQ_MUL_EARLY_EXIT_EN.
- Defined: RUN also moves to FIX when (mult >> 1) == 0 after the current step.
  - Let n = max(1, index of the highest set bit of |b| + 1).
  - out_valid rises at edge t+n+1. For b = 0, that is t+2.
- Not defined: fixed latency of WIDTH+1 cycles, independent of data.

Decomposition:
- Package seq_mul_pkg holds:
  - the state encoding (IDLE/RUN/FIX/DONE localparams or enum);
  - a count-width function clog2(WIDTH).
- One natural sub-module: seq_mul_abs. It is combinational and takes a value and a signed flag, returning the magnitude and the sign bit. It is instantiated twice at the input stage.
- Negation in FIX stays inline.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15, out_ready=1 -> res=8'hE1 (225), out_valid exactly 5 cycles after accept, in_ready low throughout.
- Signed, a=4'h8 (-8), b=4'h8 (-8) -> res=8'h40 (64). Signed, a=4'h8, b=4'h7 -> res=8'hC8 (-56).
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> res and out_valid stable, in_ready=0, no new accept. Release -> IDLE next cycle, in_ready=1.
- Assert rst during RUN (2 cycles after accept) -> next cycle: IDLE, out_valid=0, res=0. A fresh op 3*5 then returns 8'h0F.
- Exhaustive sweep: all 256 (a,b) pairs in both modes, checked against a*b (signed and unsigned reference) -> zero mismatches.
- With SEQ_MUL_EARLY_EXIT_EN: b=1 -> out_valid at t+2; b=0 -> res=0 at t+2; b=4'h8 unsigned -> t+5. Without the macro, all cases give t+5.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Optional build macro SEQ_MUL_EARLY_EXIT_EN is consumed by seq_multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// Combinational magnitude/sign split for one operand.
// Two's-complement minimum maps to 2^(WIDTH-1), which still fits unsigned.
module seq_mul_abs
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_mag_c,
  output logic             o_neg_c
);

  assign o_neg_c = i_signed & i_val[WIDTH-1];
  assign o_mag_c = o_neg_c ? WIDTH'(-i_val) : i_val;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier, signed or unsigned per op.
// Define SEQ_MUL_EARLY_EXIT_EN to end RUN once the remaining multiplier bits are zero.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mult;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic             r_neg;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_step;
  logic [WIDTH-1:0] w_mult_shift;
  logic             w_last;

  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_val    (a),
    .i_signed (signed_mode),
    .o_mag_c  (w_a_mag),
    .o_neg_c  (w_a_neg)
  );

  seq_mul_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_val    (b),
    .i_signed (signed_mode),
    .o_mag_c  (w_b_mag),
    .o_neg_c  (w_b_neg)
  );

  // One partial product per RUN cycle, weighted by the bit position being retired.
  assign w_addend     = PW'(r_mcand) << r_count;
  assign w_acc_step   = r_mult[0] ? (r_acc + w_addend) : r_acc;
  assign w_mult_shift = r_mult >> 1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign w_last = (r_count == CW'(WIDTH - 1)) || (w_mult_shift == '0);
`else
  assign w_last = (r_count == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_mult    <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_mcand  <= w_a_mag;
            r_mult   <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_count  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_step;
          r_mult  <= w_mult_shift;
          r_count <= r_count + CW'(1);
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          res       <= r_neg ? PW'(-r_acc) : r_acc;
          out_valid <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          // No accept here: in_ready only returns once back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed vector table, handshake corner sequences and exhaustive sweep for seq_multiplier.
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int W = 4;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] res;
  logic           busy;

  int checks;
  int errors;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           sm;
    logic [2*W-1:0] exp_res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Edges from accept to out_valid: WIDTH+1 fixed, or n+1 with early exit.
  function automatic int exp_lat(input logic [W-1:0] bv, input logic sm);
    logic [W-1:0] m;
    int n;
    m = (sm && bv[W-1]) ? W'(-bv) : bv;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return EARLY ? n + 1 : W + 1;
  endfunction

  // Issues one op from IDLE (called at posedge+1) and waits for out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                        output logic [2*W-1:0] r, output int lat, output logic ir_low);
    a = ta; b = tb_v; signed_mode = tsm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; signed_mode = ~tsm;
    lat = 0;
    ir_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout waiting for out_valid (a=%0h b=%0h)", ta, tb_v);
    end
    r = res;
  endtask

  vec_t vecs[10];
  logic [2*W-1:0] r;
  int lat;
  logic ir_low;
  int sa, sb;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;

    vecs[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[1] = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[2] = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[3] = '{4'h3, 4'h5, 1'b0, 8'h0F};
    vecs[4] = '{4'hF, 4'h1, 1'b1, 8'hFF};
    vecs[5] = '{4'h9, 4'h0, 1'b0, 8'h00};
    vecs[6] = '{4'h7, 4'h7, 1'b1, 8'h31};
    vecs[7] = '{4'h8, 4'h8, 1'b0, 8'h40};
    vecs[8] = '{4'hD, 4'h5, 1'b1, 8'hF1};
    vecs[9] = '{4'h1, 4'h8, 1'b0, 8'h08};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset res", 32'(res), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d idle in_ready", i), 32'(in_ready), 32'd1);
      run_op(vecs[i].va, vecs[i].vb, vecs[i].sm, r, lat, ir_low);
      chk($sformatf("vec%0d res", i), 32'(r), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat(vecs[i].vb, vecs[i].sm)));
      chk($sformatf("vec%0d in_ready low during op", i), 32'(ir_low), 32'd1);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d back to idle", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: 6*7 held for 3 cycles while new operands are offered.
    out_ready = 1'b0;
    run_op(4'h6, 4'h7, 1'b0, r, lat, ir_low);
    chk("bp res", 32'(r), 32'h2A);
    in_valid = 1'b1; a = 4'h2; b = 4'h2; signed_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d res", k), 32'(res), 32'h2A);
      chk($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp idle res held", 32'(res), 32'h2A);
    @(posedge clk); #1;
    chk("bp no stray accept", 32'(busy), 32'd0);

    // Reset two cycles into RUN aborts the op.
    a = 4'hF; b = 4'hF; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst res", 32'(res), 32'd0);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) begin
        errors++;
        $display("FAIL midrst stray out_valid after abort");
      end
    end
    run_op(4'h3, 4'h5, 1'b0, r, lat, ir_low);
    chk("post-reset 3*5", 32'(r), 32'h0F);
    chk("post-reset latency", 32'(lat), 32'(exp_lat(4'h5, 1'b0)));
    @(posedge clk); #1;

    // Exhaustive sweep in both modes.
    for (int sm = 0; sm < 2; sm++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          run_op(W'(ia), W'(ib), 1'(sm), r, lat, ir_low);
          sa = (sm == 1 && ia >= 8) ? ia - 16 : ia;
          sb = (sm == 1 && ib >= 8) ? ib - 16 : ib;
          checks++;
          if (r !== 8'(sa * sb)) begin
            errors++;
            $display("FAIL sweep sm=%0d a=%0h b=%0h: got %0h expected %0h", sm, ia, ib, r, 8'(sa * sb));
          end
          @(posedge clk); #1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
